// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcode values and FSM state encoding.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_NOR   = 3'b101;
  localparam logic [2:0] OP_PASSB = 3'b110;
  localparam logic [2:0] OP_MUL   = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the operand source (master) and the ALU (slave).
interface alu_seq_if #(parameter int WIDTH = 16);

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a_in, b_in,
    input  result, carry, zero, busy, done
  );

  modport slave (
    input  start, op, a_in, b_in,
    output result, carry, zero, busy, done
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier core: one partial product per step, WIDTH steps per multiply.
module alu_mul_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               last
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;

  // product already includes the current step's partial product, so the
  // owner can take the final value on the same edge that finishes the multiply.
  assign product = mplier[0] ? (acc + mcand) : acc;
  assign last    = (count == LAST_COUNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      count  <= '0;
    end else if (step) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU feeding the accumulator: single-cycle logic/add ops plus a
// multi-cycle MUL, with registered flags and a done pulse used as load enable.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  alu_seq_if.slave    bus
);

  state_t             state;
  logic [WIDTH-1:0]   result_q;
  logic               carry_q;
  logic               zero_q;
  logic               busy_q;
  logic               done_q;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic               mul_load;
  logic               mul_step;
  logic [2*WIDTH-1:0] mul_product;
  logic               mul_last;

  assign bus.result = result_q;
  assign bus.carry  = carry_q;
  assign bus.zero   = zero_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

  assign mul_load = ce && (state == ST_IDLE) && bus.start && (bus.op == OP_MUL);
  assign mul_step = ce && (state == ST_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .load    (mul_load),
    .step    (mul_step),
    .a       (bus.a_in),
    .b       (bus.b_in),
    .product (mul_product),
    .last    (mul_last)
  );

  // Borrow for SUB falls out of the extra top bit of the widened subtraction.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (bus.op)
      OP_ADD:   {alu_carry, alu_res} = {1'b0, bus.a_in} + {1'b0, bus.b_in};
      OP_SUB:   {alu_carry, alu_res} = {1'b0, bus.a_in} - {1'b0, bus.b_in};
      OP_AND:   alu_res = bus.a_in & bus.b_in;
      OP_OR:    alu_res = bus.a_in | bus.b_in;
      OP_XOR:   alu_res = bus.a_in ^ bus.b_in;
      OP_NOR:   alu_res = ~(bus.a_in | bus.b_in);
      OP_PASSB: alu_res = bus.b_in;
      default:  alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (ce) begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.op == OP_MUL) begin
              state  <= ST_MUL;
              busy_q <= 1'b1;
            end else begin
              result_q <= alu_res;
              carry_q  <= alu_carry;
              zero_q   <= (alu_res == '0);
              done_q   <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (mul_last) begin
            result_q <= mul_product[WIDTH-1:0];
            carry_q  <= |mul_product[2*WIDTH-1:WIDTH];
            zero_q   <= (mul_product[WIDTH-1:0] == '0);
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq with hand-computed expected values.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic ce;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_seq_if #(.WIDTH(16)) bus ();

  alu_seq #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    bus.start = s;
    bus.op    = o;
    bus.a_in  = a;
    bus.b_in  = b;
  endtask

  // Packed view {done, carry, zero, result} for compact comparisons.
  function automatic logic [18:0] obs();
    return {bus.done, bus.carry, bus.zero, bus.result};
  endfunction

  task automatic test_reset();
    logic [19:0] got;
    rst = 1'b1;
    ce  = 1'b0;
    drive(1'b0, OP_ADD, 16'h0000, 16'h0000);
    tick();
    tick();
    got = {bus.busy, obs()};
    n_cmp++;
    if (got !== 20'h00000) begin
      n_err++;
      $display("[TB] FAIL reset_state: got %h expected %h", got, 20'h00000);
    end
    rst = 1'b0;
    ce  = 1'b1;
    tick();
    got = {bus.busy, obs()};
    n_cmp++;
    if (got !== 20'h00000) begin
      n_err++;
      $display("[TB] FAIL idle_after_reset: got %h expected %h", got, 20'h00000);
    end
  endtask

  task automatic test_add();
    drive(1'b1, OP_ADD, 16'hFFFF, 16'h0001);
    tick();
    bus.start = 1'b0;
    n_cmp++;
    if (obs() !== {3'b111, 16'h0000}) begin
      n_err++;
      $display("[TB] FAIL add_wrap: got %h expected %h", obs(), {3'b111, 16'h0000});
    end
    tick();
    n_cmp++;
    if (obs() !== {3'b011, 16'h0000}) begin
      n_err++;
      $display("[TB] FAIL add_done_drop: got %h expected %h", obs(), {3'b011, 16'h0000});
    end
  endtask

  task automatic test_sub_and();
    drive(1'b1, OP_SUB, 16'h0003, 16'h0005);
    tick();
    bus.start = 1'b0;
    n_cmp++;
    if (obs() !== {3'b110, 16'hFFFE}) begin
      n_err++;
      $display("[TB] FAIL sub_borrow: got %h expected %h", obs(), {3'b110, 16'hFFFE});
    end
    tick();
    drive(1'b1, OP_AND, 16'hF0F0, 16'h0FF0);
    tick();
    bus.start = 1'b0;
    n_cmp++;
    if (obs() !== {3'b100, 16'h00F0}) begin
      n_err++;
      $display("[TB] FAIL and: got %h expected %h", obs(), {3'b100, 16'h00F0});
    end
    tick();
  endtask

  // start held high across consecutive edges: each edge produces a fresh result.
  task automatic test_back_to_back();
    logic [2:0]  ops [7];
    logic [15:0] as  [7];
    logic [15:0] bs  [7];
    logic [18:0] exp [7];
    ops = '{OP_ADD, OP_SUB, OP_OR, OP_XOR, OP_NOR, OP_NOR, OP_PASSB};
    as  = '{16'h1234, 16'h0005, 16'h00F0, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h1234};
    bs  = '{16'h1111, 16'h0005, 16'h0F00, 16'h00FF, 16'h0000, 16'h0000, 16'hABCD};
    exp = '{{3'b100, 16'h2345}, {3'b101, 16'h0000}, {3'b100, 16'h0FF0}, {3'b100, 16'hFF00},
            {3'b100, 16'hFFFF}, {3'b101, 16'h0000}, {3'b100, 16'hABCD}};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, ops[i], as[i], bs[i]);
      tick();
      n_cmp++;
      if (obs() !== exp[i]) begin
        n_err++;
        $display("[TB] FAIL b2b_op%0d: got %h expected %h", i, obs(), exp[i]);
      end
    end
    bus.start = 1'b0;
    tick();
  endtask

  task automatic test_mul();
    int busy_cycles;
    int n;
    drive(1'b1, OP_MUL, 16'h0123, 16'h0010);
    tick();
    busy_cycles = 0;
    n = 0;
    while (!bus.done && n < 40) begin
      if (bus.busy) busy_cycles++;
      if (n == 3 || n == 8) drive(1'b1, OP_ADD, 16'hFFFF, 16'hFFFF);
      else drive(1'b0, OP_ADD, 16'hFFFF, 16'hFFFF);
      tick();
      n++;
    end
    bus.start = 1'b0;
    n_cmp++;
    if (busy_cycles !== 16 || n !== 16) begin
      n_err++;
      $display("[TB] FAIL mul_timing: got busy=%0d latency=%0d expected 16/16", busy_cycles, n);
    end
    n_cmp++;
    if ({bus.busy, obs()} !== {4'b0100, 16'h1230}) begin
      n_err++;
      $display("[TB] FAIL mul_result: got %h expected %h", {bus.busy, obs()}, {4'b0100, 16'h1230});
    end
    tick();
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL mul_single_done: got %b expected 0", bus.done);
    end
  endtask

  task automatic test_mul_overflow_b2b();
    int n;
    drive(1'b1, OP_MUL, 16'h0100, 16'h0100);
    tick();
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 40) begin
      tick();
      n++;
    end
    n_cmp++;
    if (obs() !== {3'b111, 16'h0000} || n !== 16) begin
      n_err++;
      $display("[TB] FAIL mul_overflow: got %h after %0d expected %h after 16", obs(), n, {3'b111, 16'h0000});
    end
    drive(1'b1, OP_ADD, 16'h0001, 16'h0001);
    tick();
    bus.start = 1'b0;
    n_cmp++;
    if (obs() !== {3'b100, 16'h0002}) begin
      n_err++;
      $display("[TB] FAIL add_in_done_cycle: got %h expected %h", obs(), {3'b100, 16'h0002});
    end
    tick();
  endtask

  task automatic test_ce_stall();
    int n;
    drive(1'b1, OP_MUL, 16'h0007, 16'h0009);
    tick();
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 60) begin
      ce = !(n >= 4 && n < 9);
      tick();
      n++;
    end
    n_cmp++;
    if (obs() !== {3'b100, 16'h003F} || n !== 21) begin
      n_err++;
      $display("[TB] FAIL mul_stall: got %h after %0d expected %h after 21", obs(), n, {3'b100, 16'h003F});
    end
    ce = 1'b0;
    tick();
    tick();
    tick();
    n_cmp++;
    if (bus.done !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL done_hold_ce0: got %b expected 1", bus.done);
    end
    ce = 1'b1;
    tick();
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL done_release_ce1: got %b expected 0", bus.done);
    end
  endtask

  task automatic test_reset_abort();
    int dones;
    drive(1'b1, OP_MUL, 16'h0123, 16'h0010);
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({bus.busy, obs()} !== 20'h00000) begin
      n_err++;
      $display("[TB] FAIL abort_state: got %h expected %h", {bus.busy, obs()}, 20'h00000);
    end
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.done || bus.busy) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_err++;
      $display("[TB] FAIL abort_no_done: got %0d activity cycles expected 0", dones);
    end
    drive(1'b1, OP_ADD, 16'h0002, 16'h0003);
    tick();
    bus.start = 1'b0;
    n_cmp++;
    if (obs() !== {3'b100, 16'h0005}) begin
      n_err++;
      $display("[TB] FAIL add_after_abort: got %h expected %h", obs(), {3'b100, 16'h0005});
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_and();
    test_back_to_back();
    test_mul();
    test_mul_overflow_b2b();
    test_ce_stall();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
